detector_arbiter: RTL

DETECTOR_ARBITER -- requirements
Module: detector_arbiter

---
 rtl/detector_arbiter.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/detector_arbiter.sv
// ---------------------------------------------------------------------------
// detector_arbiter
//
// Two requesters share one serial sequence detector. Each requester hands
// over a DATA_W-bit frame. The frame is shifted out MSB first on ser_out
// while ser_en is high. A one-cycle drain slot follows so that a hit the
// detector reports late in the frame is still credited. A one-cycle done
// pulse then reports which requester owned the frame. Detector hits seen
// during the frame are counted per requester. The counters saturate.
//
// Ports
//   clk                       system clock, rising edge
//   reset                     asynchronous, active-low reset
//   req0_valid / req1_valid   requester has a frame pending
//   req0_data  / req1_data    frame contents [DATA_W-1:0]
//   req0_ready / req1_ready   frame taken this cycle (combinational grant)
//   ser_out                   serial bit to the shared detector
//   ser_en                    high while ser_out carries a frame bit
//   det_hit                   detector output
//   clr_cnt                   synchronous clear of both hit counters
//   done                      one-cycle pulse at end of frame
//   done_id                   owner of the finished frame
//   hit_cnt0 / hit_cnt1       saturating hit counters [CNT_W-1:0]
// ---------------------------------------------------------------------------

// Invariant monitor for the arbiter. It observes only and drives nothing.
module detector_arbiter_chk (
    input logic       clk_i,
    input logic       rst_n_i,
    input logic [1:0] state_i,
    input logic       ready0_i,
    input logic       ready1_i,
    input logic       ser_en_i,
    input logic       ser_out_i,
    input logic       done_i
);
    localparam logic [1:0] ST_SHIFT_C = 2'd1;
    localparam logic [1:0] ST_DONE_C  = 2'd3;

    // At most one requester is granted in any cycle.
    a_ready_excl: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(ready0_i && ready1_i));

    // ser_en is exactly the registered image of the SHIFT state.
    a_ser_en_state: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        ser_en_i == (state_i == ST_SHIFT_C));

    // done is exactly the registered image of the DONE state.
    a_done_state: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        done_i == (state_i == ST_DONE_C));

    // The serial line is quiet whenever no frame bit is being carried.
    a_ser_quiet: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !ser_en_i |-> !ser_out_i);
endmodule

module detector_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              ser_out,
    output logic              ser_en,
    input  logic              det_hit,
    input  logic              clr_cnt,
    output logic              done,
    output logic              done_id,
    output logic [CNT_W-1:0]  hit_cnt0,
    output logic [CNT_W-1:0]  hit_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int                BCNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_W - 1);
    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    state_e              state_q;
    logic [DATA_W-1:0]   shift_q;
    logic [BCNT_W-1:0]   bcnt_q;
    logic                owner_q;
    logic                last_q;
    logic                ser_out_q;
    logic                ser_en_q;
    logic                done_q;
    logic                done_id_q;
    logic [CNT_W-1:0]    cnt0_q;
    logic [CNT_W-1:0]    cnt0_d;
    logic [CNT_W-1:0]    cnt1_q;
    logic [CNT_W-1:0]    cnt1_d;

    logic                grant_s;
    logic                any_valid_s;
    logic                hs_s;
    logic [DATA_W-1:0]   hs_data_s;
    logic [DATA_W-1:0]   shift_nxt_s;
    logic                hit_win_s;

    assign any_valid_s = req0_valid | req1_valid;
    assign shift_nxt_s = shift_q << 1;
    assign hs_data_s   = grant_s ? req1_data : req0_data;
    assign hs_s        = req0_ready | req1_ready;
    assign hit_win_s   = det_hit && ((state_q == ST_SHIFT) || (state_q == ST_DRAIN));

    // Arbitration winner. On contention the requester not served last wins.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Combinational grant. It is only offered in IDLE and is held low while
    // reset is asserted, so no handshake can occur during reset.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (reset && (state_q == ST_IDLE) && any_valid_s) begin
            if (grant_s) begin
                req1_ready = req1_valid;
            end else begin
                req0_ready = req0_valid;
            end
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // Frame FSM: handshake, serialisation, drain slot, done pulse.
    // The outputs are registered as next-state images, so ser_en and done
    // line up exactly with the SHIFT and DONE states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= {DATA_W{1'b0}};
            bcnt_q    <= {BCNT_W{1'b0}};
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            ser_out_q <= 1'b0;
            ser_en_q  <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (hs_s) begin
                        shift_q   <= hs_data_s;
                        owner_q   <= grant_s;
                        last_q    <= grant_s;
                        bcnt_q    <= {BCNT_W{1'b0}};
                        ser_en_q  <= 1'b1;
                        ser_out_q <= hs_data_s[DATA_W-1];
                        state_q   <= ST_SHIFT;
                    end else begin
                        ser_en_q  <= 1'b0;
                        ser_out_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    shift_q <= shift_nxt_s;
                    if (bcnt_q == BCNT_LAST) begin
                        ser_en_q  <= 1'b0;
                        ser_out_q <= 1'b0;
                        state_q   <= ST_DRAIN;
                    end else begin
                        // ser_out always mirrors the MSB of the shifted word.
                        bcnt_q    <= bcnt_q + BCNT_ONE;
                        ser_en_q  <= 1'b1;
                        ser_out_q <= shift_nxt_s[DATA_W-1];
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_DRAIN: begin
                    ser_en_q  <= 1'b0;
                    ser_out_q <= 1'b0;
                    done_q    <= 1'b1;
                    done_id_q <= owner_q;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ser_en_q  <= 1'b0;
                    ser_out_q <= 1'b0;
                    done_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    // Next counter values. A clear wins over a hit arriving in the same cycle.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (clr_cnt) begin
            cnt0_d = CNT_ZERO;
            cnt1_d = CNT_ZERO;
        end else if (hit_win_s) begin
            if (owner_q) begin
                cnt1_d = sat_inc(cnt1_q);
            end else begin
                cnt0_d = sat_inc(cnt0_q);
            end
        end else begin
            cnt0_d = cnt0_q;
            cnt1_d = cnt1_q;
        end
    end

    // Hit counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0_q <= CNT_ZERO;
            cnt1_q <= CNT_ZERO;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign ser_out  = ser_out_q;
    assign ser_en   = ser_en_q;
    assign done     = done_q;
    assign done_id  = done_id_q;
    assign hit_cnt0 = cnt0_q;
    assign hit_cnt1 = cnt1_q;

    detector_arbiter_chk u_chk (
        .clk_i     (clk),
        .rst_n_i   (reset),
        .state_i   (state_q),
        .ready0_i  (req0_ready),
        .ready1_i  (req1_ready),
        .ser_en_i  (ser_en),
        .ser_out_i (ser_out),
        .done_i    (done)
    );

endmodule
